// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: opcode constants, instruction width,
// PC step, the fetch FSM state type, and the J-target helper.
package cpu_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [5:0]  OPC_J   = 6'b000010;
  localparam logic [5:0]  OPC_JAL = 6'b000011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // J-format target: region bits from the sequential PC, word index from the instruction.
  function automatic logic [31:0] j_target(input logic [31:0] pc_plus4,
                                           input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register used when a fetched word returns
// while the output register is stalled.
// Ports:
//   clk, rst           clock, async active-high reset
//   flush              drop the held entry
//   wr_valid/wr_ready  load side handshake, wr_instr/wr_pc payload
//   rd_valid/rd_ready  drain side handshake, rd_instr/rd_pc payload
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [INSTR_W-1:0] wr_instr,
  input  logic [31:0]        wr_pc,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [31:0]        rd_pc
);

  logic               full;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_q;

  assign wr_ready = !full || rd_ready;
  assign rd_valid = full;
  assign rd_instr = instr_q;
  assign rd_pc    = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (wr_valid && wr_ready) begin
      full    <= 1'b1;
      instr_q <= wr_instr;
      pc_q    <= wr_pc;
    end else if (rd_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: holds the PC, issues word reads over a
// req/ack handshake, presents {if_instr, if_pc} on a valid/ready output,
// and restarts at redirect targets.
// Parameters: RESET_PC (PC after reset), ACK_TIMEOUT (0 disables fetch_err).
// Optional macro: PC_FETCH_JUMP_PREDECODE_EN - captured J words redirect fetch.
// Ports:
//   clk, rst                      clock, async active-high reset
//   redirect_valid, redirect_pc   restart fetch at target (bits [1:0] dropped)
//   imem_req, imem_addr           read request, held until imem_ack
//   imem_ack, imem_rdata          read completion and data
//   if_valid, if_ready            output handshake
//   if_instr, if_pc               fetched word and its PC
//   fetch_err                     sticky ack-timeout flag
//
// state | meaning
// IDLE  | out of reset, request not yet issued
// FETCH | request at imem_addr outstanding
// HOLD  | output and skid entries both full, no request
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  output logic               fetch_err
);

  fetch_state_t       state;
  logic [31:0]        pc;
  logic [31:0]        stale_addr;
  logic               squash;
  logic [31:0]        pc_plus4;
  logic [31:0]        next_pc;
  logic               capture;
  logic               out_free;
  logic               to_out;
  logic               to_skid;
  logic               skid_wr_ready;
  logic               skid_rd_valid;
  logic               skid_rd_ready;
  logic               drain;
  logic [INSTR_W-1:0] skid_instr;
  logic [31:0]        skid_pc;

  assign pc_plus4 = pc + PC_STEP;

`ifdef PC_FETCH_JUMP_PREDECODE_EN
  assign next_pc = (imem_rdata[31:26] == OPC_J) ? j_target(pc_plus4, imem_rdata) : pc_plus4;
`else
  assign next_pc = pc_plus4;
`endif

  // While squashing, the stale request keeps its address until its ack.
  assign imem_req  = (state == FETCH);
  assign imem_addr = squash ? stale_addr : pc;

  // A word is kept only if it answers a live request and no redirect wins.
  assign capture       = (state == FETCH) && imem_ack && !squash && !redirect_valid;
  assign out_free      = !if_valid || if_ready;
  assign to_out        = capture && out_free;
  assign to_skid       = capture && !out_free && skid_wr_ready;
  assign skid_rd_ready = (state == HOLD) && if_ready && !redirect_valid;
  assign drain         = skid_rd_valid && skid_rd_ready;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .wr_valid (to_skid),
    .wr_ready (skid_wr_ready),
    .wr_instr (imem_rdata),
    .wr_pc    (pc),
    .rd_valid (skid_rd_valid),
    .rd_ready (skid_rd_ready),
    .rd_instr (skid_instr),
    .rd_pc    (skid_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
      squash     <= 1'b0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
    end else if (redirect_valid) begin
      state    <= FETCH;
      pc       <= redirect_pc & ~32'h3;
      if_valid <= 1'b0;
      if (state == FETCH && !imem_ack) begin
        squash     <= 1'b1;
        stale_addr <= imem_addr;
      end else begin
        squash <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack && squash) squash <= 1'b0;
          if (to_out) begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc    <= pc;
            pc       <= next_pc;
          end else begin
            if (if_valid && if_ready) if_valid <= 1'b0;
            if (to_skid) begin
              pc    <= next_pc;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (drain) begin
            if_valid <= 1'b1;
            if_instr <= skid_instr;
            if_pc    <= skid_pc;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Down-counter loaded with ACK_TIMEOUT, decremented per unacked request cycle.
  generate
    if (ACK_TIMEOUT > 0) begin : g_tmo
      logic [31:0] tmo_cnt;
      logic        err_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tmo_cnt <= 32'(ACK_TIMEOUT);
          err_q   <= 1'b0;
        end else if (imem_req && !imem_ack) begin
          if (tmo_cnt == 32'd1) err_q <= 1'b1;
          if (tmo_cnt != 32'd0) tmo_cnt <= tmo_cnt - 32'd1;
        end else begin
          tmo_cnt <= 32'(ACK_TIMEOUT);
        end
      end
      assign fetch_err = err_q;
    end else begin : g_no_tmo
      assign fetch_err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_err;

  pc_fetch #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_err      (fetch_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  logic        ack_en = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] exp_next;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1111_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] w);
    sb_q.push_back({p, w});
  endtask

  // Instruction memory: acks at the negedge so the ack is stable at the next posedge.
  initial forever begin
    @(negedge clk);
    if (!rst && imem_req && ack_en) begin
      imem_ack   = 1'b1;
      imem_rdata = ovr_en ? ovr_data : mem_word(imem_addr);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
    end
  end

  // Monitor: pops the scoreboard on every output transfer, and checks the
  // request address is held while unacked.
  always @(negedge clk) begin
    #1;
    if (!rst && if_valid && if_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_delivery: got pc %h instr %h, required no delivery", if_pc, if_instr);
      end else begin
        mon_e = sb_q.pop_front();
        check("deliv_pc", if_pc, mon_e.pc);
        check("deliv_instr", if_instr, mon_e.instr);
      end
    end
    if (!rst && prev_req && !prev_ack && imem_req)
      check("addr_stable", imem_addr, prev_addr);
    prev_req  = rst ? 1'b0 : imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
  end

  task automatic do_reset();
    rst            = 1'b1;
    ack_en         = 1'b0;
    ovr_en         = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("rst_async_req", imem_req, 0);
    check("rst_async_valid", if_valid, 0);
    tick();
    tick();
    check("rst_addr", imem_addr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_err", fetch_err, 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    do_reset();

    // 1: sequential streaming, then reset mid-fetch
    push(32'h0, 32'h1111_0000);
    push(32'h4, 32'h1111_0004);
    push(32'h8, 32'h1111_0008);
    if_ready = 1'b1; ack_en = 1'b1; rst = 1'b0;
    tick();
    check("t1_req", imem_req, 1);
    check("t1_addr0", imem_addr, 32'h0);
    tick();
    check("t1_addr4", imem_addr, 32'h4);
    tick();
    check("t1_addr8", imem_addr, 32'h8);
    tick();
    check("t1_addrC", imem_addr, 32'hC);
    tick();
    do_reset();

    // 2: stall into HOLD, then drain in order
    push(32'h0, 32'h1111_0000);
    push(32'h4, 32'h1111_0004);
    if_ready = 1'b0; ack_en = 1'b1; rst = 1'b0;
    tick();
    tick();
    check("t2_valid", if_valid, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_req", imem_req, 0);
      check("t2_hold_pc", if_pc, 32'h0);
      check("t2_hold_valid", if_valid, 1);
      tick();
    end
    if_ready = 1'b1;
    tick();
    check("t2_resume_req", imem_req, 1);
    check("t2_resume_addr", imem_addr, 32'h8);
    ack_en = 1'b0;
    tick();
    tick();
    do_reset();

    // 3: redirect with an outstanding request; stale word discarded
    push(32'h0, 32'h1111_0000);
    push(32'h4, 32'h1111_0004);
    push(32'h400, 32'h1111_0400);
    if_ready = 1'b1; ack_en = 1'b1; rst = 1'b0;
    tick(); tick(); tick();
    check("t3_addr8", imem_addr, 32'h8);
    ack_en = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0403;
    tick();
    redirect_valid = 1'b0;
    check("t3_squash_req", imem_req, 1);
    check("t3_squash_addr", imem_addr, 32'h8);
    check("t3_flush_valid", if_valid, 0);
    tick();
    ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF; ack_en = 1'b1;
    tick();
    ovr_en = 1'b0;
    check("t3_redir_req", imem_req, 1);
    check("t3_redir_addr", imem_addr, 32'h400);
    check("t3_stale_dropped", if_valid, 0);
    tick();
    check("t3_next_addr", imem_addr, 32'h404);
    check("t3_no_err", fetch_err, 0);
    ack_en = 1'b0;
    tick(); tick();
    do_reset();

    // 4: redirect coinciding with an ack, then PC wrap
    push(32'hFFFF_FFFC, 32'h1111_FFFC);
    push(32'h0, 32'h1111_0000);
    if_ready = 1'b1; ack_en = 1'b1; rst = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("t4_redir_addr", imem_addr, 32'hFFFF_FFFC);
    check("t4_ack_dropped", if_valid, 0);
    tick();
    check("t4_wrap_addr", imem_addr, 32'h0);
    check("t4_top_pc", if_pc, 32'hFFFF_FFFC);
    tick();
    check("t4_after_wrap", imem_addr, 32'h4);
    ack_en = 1'b0;
    tick(); tick();
    do_reset();

    // 5: ack timeout is sticky
    push(32'h0, 32'h1111_0000);
    if_ready = 1'b1; ack_en = 1'b0; rst = 1'b0;
    tick();
    tick();
    tick();
    check("t5_err_early", fetch_err, 0);
    tick(); tick(); tick();
    check("t5_err_set", fetch_err, 1);
    check("t5_still_req", imem_req, 1);
    ack_en = 1'b1;
    tick();
    ack_en = 1'b0;
    check("t5_err_after_ack", fetch_err, 1);
    check("t5_delivered_valid", if_valid, 1);
    tick(); tick(); tick();
    check("t5_err_hold", fetch_err, 1);
    do_reset();

    // 6: J word handling
`ifdef PC_FETCH_JUMP_PREDECODE_EN
    exp_next = 32'h1000_0100;
`else
    exp_next = 32'h1000_0014;
`endif
    push(32'h1000_0010, 32'h0800_0040);
    if_ready = 1'b1; ack_en = 1'b0; rst = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h1000_0010;
    tick();
    redirect_valid = 1'b0;
    check("t6_req", imem_req, 1);
    check("t6_addr", imem_addr, 32'h1000_0010);
    ovr_en = 1'b1; ovr_data = 32'h0800_0040; ack_en = 1'b1;
    tick();
    ovr_en = 1'b0; ack_en = 1'b0;
    check("t6_next_addr", imem_addr, exp_next);
    tick(); tick();
    check("sb_final", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Instruction-fetch front end that sources the `pc_in`/`instru` pair consumed by the jump unit and decode.
- Holds the architectural PC and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction with its PC through a valid/ready interface.
- Accepts redirects (jump/branch target) that flush in-flight work and restart fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ACK_TIMEOUT, 0, cycles to wait for imem_ack before flagging `fetch_err`; 0 disables the check.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored, forced to 00.
- imem_req  out  1  memory read request.
- imem_addr  out  32  word address; stable while imem_req=1.
- imem_ack  in  1  read data valid; completes the request.
- imem_rdata  in  32  instruction word, sampled when imem_ack=1.
- if_valid  out  1  if_instr/if_pc hold a valid fetched instruction.
- if_ready  in  1  downstream accepts; transfer when if_valid & if_ready.
- if_instr  out  32  fetched instruction (jump unit `instru`).
- if_pc  out  32  PC of if_instr (jump unit `pc_in`).
- fetch_err  out  1  sticky: ack timeout; cleared only by rst.

Behaviour:
Reset (async, rst=1):
- pc=RESET_PC, state=IDLE, squash=0.
- Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fetch_err=0.

FSM states IDLE, FETCH, HOLD:
- IDLE: entered only from reset. Goes to FETCH on the first clock with rst=0.
- FETCH: imem_req=1, imem_addr=pc. The request must be held with a constant address until imem_ack.
  - On ack with the output register empty or being drained (if_ready=1): capture if_instr=imem_rdata and if_pc=pc; set if_valid=1 next cycle; pc<=pc+4; stay in FETCH. The new request is issued the next cycle, giving sustained throughput of 1 instruction per cycle with single-cycle ack.
  - On ack while if_valid=1 and if_ready=0: go to HOLD with the captured word in the single-entry skid register; pc<=pc+4.
- HOLD: imem_req=0; the output register and skid register are both full. When if_ready=1, the skid entry moves to the output and the FSM returns to FETCH.
- if_valid deasserts only after a transfer with no replacement word.

Redirect (highest priority):
- Next cycle: pc<=redirect_pc, if_valid=0, skid entry dropped, state=FETCH.
- If a request is outstanding without an ack that cycle, set squash=1. The next imem_ack completes that stale request; its data is discarded, squash clears, and only then is a new request issued at the redirect address.
- An ack coinciding with a redirect is discarded, and no squash is set.
- A redirect during HOLD or IDLE: no squash is needed.

Arithmetic and timing:
- PC+4 is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- ACK_TIMEOUT > 0: a counter runs while imem_req=1 and no ack. On reaching ACK_TIMEOUT, fetch_err=1 (sticky). Fetch continues waiting.
- Latency: reset release → first imem_req 1 cycle. Ack → if_valid 1 cycle.

Optional Feature:
- Macro: PC_FETCH_JUMP_PREDECODE_EN.
- Defined: on a captured word with imem_rdata[31:26]=6'b000010 (J), fetch self-redirects. The next pc is {pc_plus4[31:28], imem_rdata[25:0], 2'b00}, not pc+4. The J word itself is still delivered. An external redirect in the same cycle wins.
- Undefined: J is fetched sequentially and only the external redirect changes the flow.

Decomposition:
- Shared package `cpu_pkg`: OPC_J=6'b000010, OPC_JAL=6'b000011, INSTR_W=32, PC_STEP=4, fetch state enum typedef (IDLE/FETCH/HOLD).
- Sub-module `fetch_skid_buf`: one-entry {instr, pc} holding register with valid/ready in and out, plus a flush input.

Test Plan:
1. Reset then release, single-cycle ack, if_ready=1 → imem_addr 0,4,8,C on consecutive requests; if_pc 0,4,8 with one instruction per cycle; rst mid-fetch clears if_valid and imem_req immediately.
2. if_ready=0 for 5 cycles after two acks → FSM in HOLD, imem_req=0, if_pc stays 0. Raising if_ready delivers pc 0 then 4 in order; fetch resumes at 8.
3. Redirect to 32'h0000_0403 while a request at 8 is outstanding, ack 3 cycles later with 32'hDEAD_BEEF → word discarded; next request at 32'h0000_0400; first delivered if_pc=400.
4. Redirect to 32'hFFFF_FFFC → deliveries at FFFF_FFFC, then 0000_0000 (wrap).
5. ACK_TIMEOUT=4, ack withheld 6 cycles → fetch_err=1 from the 4th waiting cycle and stays set after the ack.
6. With PC_FETCH_JUMP_PREDECODE_EN, pc=32'h1000_0010, word 32'h0800_0040 → J delivered with if_pc 1000_0010; next imem_addr 32'h1000_0100. Without the macro, next imem_addr is 1000_0014.
